cm0_dap_cdc_recv_hs: RTL and testbench

//  Receive end of a 4-phase REQ/ACK clock-domain-crossing handshake in the DAP.

---
 rtl/cm0_dap_cdc_recv_hs_if.sv | 35 +++
 rtl/cm0_dap_cdc_recv_hs.sv | 145 ++++++++++++++
 tb/tb_cm0_dap_cdc_recv_hs.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cm0_dap_cdc_recv_hs_if.sv
// ---------------------------------------------------------------------------
// cm0_dap_cdc_recv_hs_if
// Purpose : bundles the REQ/ACK crossing signals and the local consumer
//           signals of the DAP handshake receiver.
// Signals :
//   REQIN   request from the sending domain (asynchronous to REGCLK)
//   DATAIN  payload, held stable by the sender while REQIN=1
//   RDY     local consumer can accept a word this cycle
//   ACKOUT  acknowledge back to the sending domain (flop output)
//   DATAOUT last captured payload
//   VALID   one-cycle pulse when DATAOUT is updated
//   BUSY    receiver is not idle
// Modports: master = sender/consumer side, slave = receiver block.
// ---------------------------------------------------------------------------
interface cm0_dap_cdc_recv_hs_if #(
    parameter int DW = 32
);
    logic          REQIN;
    logic [DW-1:0] DATAIN;
    logic          RDY;
    logic          ACKOUT;
    logic [DW-1:0] DATAOUT;
    logic          VALID;
    logic          BUSY;

    modport master (
        output REQIN, DATAIN, RDY,
        input  ACKOUT, DATAOUT, VALID, BUSY
    );

    modport slave (
        input  REQIN, DATAIN, RDY,
        output ACKOUT, DATAOUT, VALID, BUSY
    );
endinterface

// File: rtl/cm0_dap_cdc_recv_hs.sv
// ---------------------------------------------------------------------------
// cm0_dap_cdc_recv_hs
// Purpose : receive end of a 4-phase REQ/ACK clock-domain-crossing handshake.
//           REQIN is synchronised into REGCLK, DATAIN is captured with a load
//           enable once the local consumer is ready, and ACKOUT is returned
//           straight from a flop so the sending domain never sees a glitch.
// Parameters:
//   PRESENT     1 = block implemented, 0 = all outputs tied to 0
//   DW          payload width
//   SYNC_STAGES depth of the REQIN synchroniser (>= 2)
// Ports:
//   REGCLK        local clock
//   RARREGRESETn  asynchronous active-low reset
//   SE            scan enable, no functional effect
//   hs            handshake/consumer bundle (slave side)
// ---------------------------------------------------------------------------
module cm0_dap_cdc_recv_hs #(
    parameter bit PRESENT     = 1'b1,
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        REGCLK,
    input  logic                        RARREGRESETn,
    input  logic                        SE,
    cm0_dap_cdc_recv_hs_if.slave        hs
);

    // Scan enable only matters to the DFT flow.
    logic unused_se;
    assign unused_se = SE;

`ifdef ARM_ASSERT_ON
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $fatal(1, "cm0_dap_cdc_recv_hs: SYNC_STAGES must be >= 2");
    end
`endif

    generate
        if (PRESENT) begin : g_present
            localparam logic [1:0] ST_IDLE = 2'd0;
            localparam logic [1:0] ST_PEND = 2'd1;
            localparam logic [1:0] ST_ACK  = 2'd2;

            logic [SYNC_STAGES-1:0] sync_q;
            logic                   reqs;
            logic [1:0]             state_q, state_d;
            logic                   ack_q, ack_d;
            logic                   valid_q, valid_d;
            logic                   cap_en;
            logic [DW-1:0]          data_q;

            // REQIN synchroniser: the only flop that looks at REQIN.
            always_ff @(posedge REGCLK or negedge RARREGRESETn) begin
                if (!RARREGRESETn) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], hs.REQIN};
                end
            end

            assign reqs = sync_q[SYNC_STAGES-1];

            always_comb begin
                state_d = state_q;
                ack_d   = ack_q;
                valid_d = 1'b0;
                cap_en  = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (reqs) begin
                            if (hs.RDY) begin
                                cap_en  = 1'b1;
                                valid_d = 1'b1;
                                ack_d   = 1'b1;
                                state_d = ST_ACK;
                            end else begin
                                state_d = ST_PEND;
                            end
                        end
                    end
                    ST_PEND: begin
                        if (!reqs) begin
                            // Sender withdrew before we were ready: nothing captured.
                            state_d = ST_IDLE;
                        end else if (hs.RDY) begin
                            cap_en  = 1'b1;
                            valid_d = 1'b1;
                            ack_d   = 1'b1;
                            state_d = ST_ACK;
                        end
                    end
                    ST_ACK: begin
                        // RDY is deliberately ignored here: one word per REQ phase.
                        if (!reqs) begin
                            ack_d   = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        ack_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                endcase
            end

            always_ff @(posedge REGCLK or negedge RARREGRESETn) begin
                if (!RARREGRESETn) begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    valid_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    ack_q   <= ack_d;
                    valid_q <= valid_d;
                end
            end

            // DATAIN is only ever loaded on the capture edge, so an undefined
            // bus outside the REQ phase cannot reach DATAOUT.
            always_ff @(posedge REGCLK or negedge RARREGRESETn) begin
                if (!RARREGRESETn) begin
                    data_q <= '0;
                end else if (cap_en) begin
                    data_q <= hs.DATAIN;
                end
            end

            // ACKOUT is the bare flop output: no gating after the register.
            assign hs.ACKOUT  = ack_q;
            assign hs.DATAOUT = data_q;
            assign hs.VALID   = valid_q;
            assign hs.BUSY    = (state_q != ST_IDLE);
        end else begin : g_absent
            logic unused_in;
            assign unused_in = &{1'b0, hs.REQIN, hs.DATAIN, hs.RDY,
                                 REGCLK, RARREGRESETn};

            assign hs.ACKOUT  = 1'b0;
            assign hs.DATAOUT = '0;
            assign hs.VALID   = 1'b0;
            assign hs.BUSY    = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_cm0_dap_cdc_recv_hs.sv
`timescale 1ns/1ps
module tb_cm0_dap_cdc_recv_hs;

    logic REGCLK;
    logic RARREGRESETn;
    logic SE;

    cm0_dap_cdc_recv_hs_if #(.DW(32)) hs_if ();

    cm0_dap_cdc_recv_hs #(
        .PRESENT    (1'b1),
        .DW         (32),
        .SYNC_STAGES(2)
    ) dut (
        .REGCLK      (REGCLK),
        .RARREGRESETn(RARREGRESETn),
        .SE          (SE),
        .hs          (hs_if)
    );

    initial begin
        REGCLK = 1'b0;
        forever #5 REGCLK = ~REGCLK;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int ack_rises = 0;
    logic ack_prev = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge REGCLK);
        #1;
    endtask

    // Scoreboard consumer: every VALID pulse pops one expected word.
    always @(negedge REGCLK) begin
        if (hs_if.ACKOUT && !ack_prev) ack_rises++;
        ack_prev <= hs_if.ACKOUT;
        if (hs_if.VALID === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("valid_unexp", 32'd1, 32'd0);
            end else begin
                check("sb_dataout", hs_if.DATAOUT, exp_q.pop_front());
            end
        end
    end

    initial begin
        int v0, a0, polls;
        logic [31:0] d;

        SE           = 1'b0;
        RARREGRESETn = 1'b0;
        hs_if.REQIN  = 1'b1;
        hs_if.DATAIN = 32'hA5A5_5A5A;
        hs_if.RDY    = 1'b1;

        // 1: reset held with an active request
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_ack",   {31'd0, hs_if.ACKOUT}, 32'd0);
            check("rst_valid", {31'd0, hs_if.VALID},  32'd0);
            check("rst_data",  hs_if.DATAOUT,         32'd0);
            check("rst_busy",  {31'd0, hs_if.BUSY},   32'd0);
        end
        hs_if.REQIN = 1'b0;
        tick(2);
        RARREGRESETn = 1'b1;
        tick(2);

        // 2: basic transfer, capture at edge 3
        hs_if.DATAIN = 32'h1234_5678;
        hs_if.REQIN  = 1'b1;
        exp_q.push_back(32'h1234_5678);
        tick(2);
        check("b_ack_e2",   {31'd0, hs_if.ACKOUT}, 32'd0);
        check("b_valid_e2", {31'd0, hs_if.VALID},  32'd0);
        tick(1);
        check("b_valid_e3", {31'd0, hs_if.VALID},  32'd1);
        check("b_ack_e3",   {31'd0, hs_if.ACKOUT}, 32'd1);
        check("b_data_e3",  hs_if.DATAOUT,         32'h1234_5678);
        tick(1);
        check("b_valid_e4", {31'd0, hs_if.VALID},  32'd0);
        hs_if.REQIN = 1'b0;
        tick(2);
        check("b_ack_hold", {31'd0, hs_if.ACKOUT}, 32'd1);
        tick(1);
        check("b_ack_rel",  {31'd0, hs_if.ACKOUT}, 32'd0);
        check("b_busy_rel", {31'd0, hs_if.BUSY},   32'd0);
        check("b_data_hld", hs_if.DATAOUT,         32'h1234_5678);
        tick(2);

        // 3: backpressure, single capture on first RDY edge
        v0 = valid_cnt;
        hs_if.RDY    = 1'b0;
        hs_if.DATAIN = 32'hCAFE_F00D;
        hs_if.REQIN  = 1'b1;
        tick(10);
        check("bp_busy",   {31'd0, hs_if.BUSY},   32'd1);
        check("bp_novalid", valid_cnt - v0,       32'd0);
        check("bp_noack",  {31'd0, hs_if.ACKOUT}, 32'd0);
        hs_if.RDY = 1'b1;
        exp_q.push_back(32'hCAFE_F00D);
        tick(1);
        check("bp_valid",  {31'd0, hs_if.VALID},  32'd1);
        check("bp_data",   hs_if.DATAOUT,         32'hCAFE_F00D);
        tick(6);
        check("bp_one",    valid_cnt - v0,        32'd1);
        hs_if.REQIN = 1'b0;
        tick(4);
        check("bp_ack_rel", {31'd0, hs_if.ACKOUT}, 32'd0);

        // 4: withdrawal while not ready
        v0 = valid_cnt;
        hs_if.RDY    = 1'b0;
        hs_if.DATAIN = 32'hDEAD_BEEF;
        hs_if.REQIN  = 1'b1;
        tick(4);
        check("wd_busy",  {31'd0, hs_if.BUSY}, 32'd1);
        hs_if.REQIN  = 1'b0;
        hs_if.DATAIN = 'x;
        tick(4);
        check("wd_idle",  {31'd0, hs_if.BUSY},   32'd0);
        check("wd_noval", valid_cnt - v0,        32'd0);
        check("wd_data",  hs_if.DATAOUT,         32'hCAFE_F00D);
        check("wd_noack", {31'd0, hs_if.ACKOUT}, 32'd0);
        hs_if.RDY = 1'b1;
        tick(1);

        // 5: eight handshakes from a sender stepping every 27 ns
        v0 = valid_cnt;
        a0 = ack_rises;
        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            hs_if.DATAIN = d;
            hs_if.REQIN  = 1'b1;
            exp_q.push_back(d);
            polls = 0;
            while (hs_if.ACKOUT !== 1'b1 && polls < 40) begin
                #27; polls++;
            end
            if (polls >= 40) check("s_ack_tmo", 32'd1, 32'd0);
            hs_if.REQIN = 1'b0;
            polls = 0;
            while (hs_if.ACKOUT !== 1'b0 && polls < 40) begin
                #27; polls++;
            end
            if (polls >= 40) check("s_rel_tmo", 32'd1, 32'd0);
            hs_if.DATAIN = 'x;
            #27;
        end
        tick(3);
        check("s_valids",  valid_cnt - v0, 32'd8);
        check("s_ackedge", ack_rises - a0, 32'd8);
        check("s_qempty",  exp_q.size(),   32'd0);

        // 6: reset while in ACK
        hs_if.DATAIN = 32'h0BAD_F00D;
        hs_if.REQIN  = 1'b1;
        exp_q.push_back(32'h0BAD_F00D);
        tick(4);
        check("r_ack_pre", {31'd0, hs_if.ACKOUT}, 32'd1);
        RARREGRESETn = 1'b0;
        #1;
        check("r_ack_async", {31'd0, hs_if.ACKOUT}, 32'd0);
        check("r_busy",      {31'd0, hs_if.BUSY},   32'd0);
        check("r_data",      hs_if.DATAOUT,         32'd0);
        hs_if.REQIN = 1'b0;
        tick(2);
        RARREGRESETn = 1'b1;
        tick(3);
        check("r_idle", {31'd0, hs_if.BUSY}, 32'd0);
        hs_if.DATAIN = 32'h55AA_33CC;
        hs_if.REQIN  = 1'b1;
        exp_q.push_back(32'h55AA_33CC);
        tick(3);
        check("r_valid", {31'd0, hs_if.VALID}, 32'd1);
        check("r_data2", hs_if.DATAOUT,        32'h55AA_33CC);
        hs_if.REQIN = 1'b0;
        tick(3);
        check("r_ack_rel", {31'd0, hs_if.ACKOUT}, 32'd0);
        tick(2);
        check("end_qempty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
